// File: rtl/rs_issue_scheduler.sv
// Reservation station: holds renamed ops, snoops writeback tags, issues the oldest ready op per FU.
// Build option RS_FAST_WAKEUP_EN lets same-cycle broadcasts feed selection.
module rs_issue_scheduler #(
   parameter int RS_DEPTH = 16,
   parameter int NUM_FU   = 3,
   parameter int PREG_W   = 6,
   parameter int ROB_W    = 4,
   parameter int OP_W     = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [OP_W-1:0]          disp_op,
   input  logic [PREG_W-1:0]        disp_pd,
   input  logic [PREG_W-1:0]        disp_ps1,
   input  logic                     disp_ps1_rdy,
   input  logic [PREG_W-1:0]        disp_ps2,
   input  logic                     disp_ps2_rdy,
   input  logic [1:0]               disp_fu,
   input  logic [ROB_W-1:0]         disp_rob,
   input  logic [NUM_FU-1:0]        wb_valid,
   input  logic [NUM_FU*PREG_W-1:0] wb_preg,
   input  logic [NUM_FU-1:0]        fu_busy,
   output logic [NUM_FU-1:0]        issue_valid,
   output logic [NUM_FU*OP_W-1:0]   issue_op,
   output logic [NUM_FU*PREG_W-1:0] issue_pd,
   output logic [NUM_FU*PREG_W-1:0] issue_ps1,
   output logic [NUM_FU*PREG_W-1:0] issue_ps2,
   output logic [NUM_FU*ROB_W-1:0]  issue_rob,
   output logic [4:0]               occupancy,
   output logic                     err_fu
);
   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [RS_DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
   logic [OP_W-1:0]     r_op  [RS_DEPTH];
   logic [PREG_W-1:0]   r_pd  [RS_DEPTH];
   logic [PREG_W-1:0]   r_ps1 [RS_DEPTH];
   logic [PREG_W-1:0]   r_ps2 [RS_DEPTH];
   logic [1:0]          r_fu  [RS_DEPTH];
   logic [ROB_W-1:0]    r_rob [RS_DEPTH];
   // r_older[r][j] set means row j was allocated before row r
   logic [RS_DEPTH-1:0] r_older [RS_DEPTH];

   logic [RS_DEPTH-1:0] w_wake1, w_wake2, w_sel_rdy1, w_sel_rdy2, w_issue_rows;
   logic                w_byp1, w_byp2, w_alloc_hit, w_fu_bad, w_disp_fire, w_accept;
   logic [IDX_W-1:0]    w_alloc_idx;
   logic [NUM_FU-1:0]   w_iss;
   logic [IDX_W-1:0]    w_iss_idx [NUM_FU];
   logic [4:0]          w_nissue;

   function automatic logic f_snoop(input logic [PREG_W-1:0] src,
                                    input logic [NUM_FU-1:0] v,
                                    input logic [NUM_FU*PREG_W-1:0] p);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_FU; k++)
         if (v[k] && p[k*PREG_W +: PREG_W] == src) hit = 1'b1;
      return hit;
   endfunction

   assign disp_ready = (32'(occupancy) < RS_DEPTH);

   always_comb begin
      logic [RS_DEPTH-1:0] cand;
      w_wake1 = '0;
      w_wake2 = '0;
      for (int unsigned r = 0; r < RS_DEPTH; r++) begin
         w_wake1[r] = f_snoop(r_ps1[r], wb_valid, wb_preg);
         w_wake2[r] = f_snoop(r_ps2[r], wb_valid, wb_preg);
      end
      w_byp1 = f_snoop(disp_ps1, wb_valid, wb_preg);
      w_byp2 = f_snoop(disp_ps2, wb_valid, wb_preg);
`ifdef RS_FAST_WAKEUP_EN
      w_sel_rdy1 = r_rdy1 | w_wake1;
      w_sel_rdy2 = r_rdy2 | w_wake2;
`else
      w_sel_rdy1 = r_rdy1;
      w_sel_rdy2 = r_rdy2;
`endif
      w_alloc_hit = 1'b0;
      w_alloc_idx = '0;
      for (int unsigned r = 0; r < RS_DEPTH; r++)
         if (!r_valid[r] && !w_alloc_hit) begin
            w_alloc_hit = 1'b1;
            w_alloc_idx = IDX_W'(r);
         end
      w_fu_bad    = (32'(disp_fu) >= NUM_FU);
      w_disp_fire = disp_valid && disp_ready && !flush;
      w_accept    = w_disp_fire && !w_fu_bad && w_alloc_hit;

      w_issue_rows = '0;
      w_iss        = '0;
      w_nissue     = '0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
         cand         = '0;
         w_iss_idx[f] = '0;
         for (int unsigned r = 0; r < RS_DEPTH; r++)
            cand[r] = r_valid[r] && w_sel_rdy1[r] && w_sel_rdy2[r] && (32'(r_fu[r]) == f);
         // the oldest candidate is the one with no older candidate in its age row
         for (int unsigned r = 0; r < RS_DEPTH; r++)
            if (cand[r] && !(|(cand & r_older[r]))) begin
               w_iss_idx[f] = IDX_W'(r);
               w_iss[f]     = !fu_busy[f] && !flush;
            end
         if (w_iss[f]) begin
            w_issue_rows[w_iss_idx[f]] = 1'b1;
            w_nissue = w_nissue + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= '0;
         for (int unsigned r = 0; r < RS_DEPTH; r++) r_older[r] <= '0;
         issue_valid <= '0;
         issue_op    <= '0;
         issue_pd    <= '0;
         issue_ps1   <= '0;
         issue_ps2   <= '0;
         issue_rob   <= '0;
         occupancy   <= '0;
         err_fu      <= 1'b0;
      end else begin
         if (w_disp_fire && w_fu_bad) err_fu <= 1'b1;
         if (flush) begin
            r_valid     <= '0;
            issue_valid <= '0;
            occupancy   <= '0;
         end else begin
            issue_valid <= w_iss;
            occupancy   <= occupancy + 5'(w_accept) - w_nissue;
            r_valid     <= r_valid & ~w_issue_rows;
            for (int unsigned f = 0; f < NUM_FU; f++)
               if (w_iss[f]) begin
                  issue_op [f*OP_W   +: OP_W]   <= r_op [w_iss_idx[f]];
                  issue_pd [f*PREG_W +: PREG_W] <= r_pd [w_iss_idx[f]];
                  issue_ps1[f*PREG_W +: PREG_W] <= r_ps1[w_iss_idx[f]];
                  issue_ps2[f*PREG_W +: PREG_W] <= r_ps2[w_iss_idx[f]];
                  issue_rob[f*ROB_W  +: ROB_W]  <= r_rob[w_iss_idx[f]];
               end
            if (w_accept) begin
               r_valid[w_alloc_idx] <= 1'b1;
               r_older[w_alloc_idx] <= r_valid;
               for (int unsigned r = 0; r < RS_DEPTH; r++)
                  if (IDX_W'(r) != w_alloc_idx) r_older[r][w_alloc_idx] <= 1'b0;
            end
         end
      end
   end

   // Payload and ready bits are qualified by r_valid, so they need no reset.
   always_ff @(posedge clk) begin
      r_rdy1 <= r_rdy1 | w_wake1;
      r_rdy2 <= r_rdy2 | w_wake2;
      if (w_accept) begin
         r_op [w_alloc_idx]  <= disp_op;
         r_pd [w_alloc_idx]  <= disp_pd;
         r_ps1[w_alloc_idx]  <= disp_ps1;
         r_ps2[w_alloc_idx]  <= disp_ps2;
         r_fu [w_alloc_idx]  <= disp_fu;
         r_rob[w_alloc_idx]  <= disp_rob;
         r_rdy1[w_alloc_idx] <= disp_ps1_rdy | w_byp1;
         r_rdy2[w_alloc_idx] <= disp_ps2_rdy | w_byp2;
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios then random traffic against an age-ordered queue model.
module tb_rs_issue_scheduler;
   localparam int NF = 3, PW = 6, OW = 7, RW = 4, DEPTH = 16;
`ifdef RS_FAST_WAKEUP_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, flush, disp_valid, disp_ready, disp_ps1_rdy, disp_ps2_rdy, err_fu;
   logic [OW-1:0] disp_op;
   logic [PW-1:0] disp_pd, disp_ps1, disp_ps2;
   logic [1:0] disp_fu;
   logic [RW-1:0] disp_rob;
   logic [NF-1:0] wb_valid, fu_busy, issue_valid;
   logic [NF*PW-1:0] wb_preg, issue_pd, issue_ps1, issue_ps2;
   logic [NF*OW-1:0] issue_op;
   logic [NF*RW-1:0] issue_rob;
   logic [4:0] occupancy;

   rs_issue_scheduler #(.RS_DEPTH(DEPTH), .NUM_FU(NF), .PREG_W(PW), .ROB_W(RW), .OP_W(OW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_op(disp_op), .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
      .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy), .disp_fu(disp_fu), .disp_rob(disp_rob),
      .wb_valid(wb_valid), .wb_preg(wb_preg), .fu_busy(fu_busy), .issue_valid(issue_valid),
      .issue_op(issue_op), .issue_pd(issue_pd), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
      .issue_rob(issue_rob), .occupancy(occupancy), .err_fu(err_fu));

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] op;
      logic [PW-1:0] pd, ps1, ps2;
      logic r1, r2;
      logic [1:0] fu;
      logic [RW-1:0] rob;
   } ent_t;

   ent_t q[$];  // held entries, oldest first
   logic [OW-1:0] e_op [NF];
   logic [PW-1:0] e_pd [NF], e_ps1 [NF], e_ps2 [NF];
   logic [RW-1:0] e_rob [NF];
   logic e_err = 1'b0;
   int n_pass = 0, n_total = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit bc(input logic [PW-1:0] p);
      for (int k = 0; k < NF; k++)
         if (wb_valid[k] && wb_preg[k*PW +: PW] == p) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit sel_ready(input ent_t e);
      return (e.r1 || (FAST && bc(e.ps1))) && (e.r2 || (FAST && bc(e.ps2)));
   endfunction

   task automatic idle();
      disp_valid = 1'b0; flush = 1'b0; wb_valid = '0; wb_preg = '0;
   endtask

   task automatic disp(input logic [OW-1:0] op, input logic [PW-1:0] pd, input logic [PW-1:0] s1,
                       input logic r1, input logic [PW-1:0] s2, input logic r2,
                       input logic [1:0] fu, input logic [RW-1:0] rob);
      disp_valid = 1'b1; disp_op = op; disp_pd = pd; disp_ps1 = s1; disp_ps1_rdy = r1;
      disp_ps2 = s2; disp_ps2_rdy = r2; disp_fu = fu; disp_rob = rob;
   endtask

   task automatic bcast(input int k, input logic [PW-1:0] p);
      wb_valid[k] = 1'b1;
      wb_preg[k*PW +: PW] = p;
   endtask

   // Predict one clock edge from the model and current inputs, then compare after it.
   task automatic cycle();
      bit exp_dr, keep;
      logic [NF-1:0] exp_iv;
      int pick [NF];
      ent_t nq[$];
      ent_t e;
      exp_dr = (q.size() < DEPTH);
      chk("disp_ready", 64'(disp_ready), 64'(exp_dr));
      exp_iv = '0;
      if (flush) q.delete();
      else begin
         for (int f = 0; f < NF; f++) begin
            pick[f] = -1;
            if (!fu_busy[f])
               for (int i = 0; i < q.size(); i++)
                  if (int'(q[i].fu) == f && sel_ready(q[i])) begin pick[f] = i; break; end
            if (pick[f] >= 0) begin
               exp_iv[f] = 1'b1;
               e_op[f] = q[pick[f]].op;   e_pd[f]  = q[pick[f]].pd;
               e_ps1[f] = q[pick[f]].ps1; e_ps2[f] = q[pick[f]].ps2;
               e_rob[f] = q[pick[f]].rob;
            end
         end
         for (int i = 0; i < q.size(); i++) begin
            keep = 1'b1;
            for (int f = 0; f < NF; f++) if (pick[f] == i) keep = 1'b0;
            if (keep) begin
               e = q[i];
               e.r1 = e.r1 | bc(e.ps1);
               e.r2 = e.r2 | bc(e.ps2);
               nq.push_back(e);
            end
         end
         if (disp_valid && exp_dr) begin
            if (int'(disp_fu) >= NF) e_err = 1'b1;
            else begin
               e.op = disp_op; e.pd = disp_pd; e.ps1 = disp_ps1; e.ps2 = disp_ps2;
               e.r1 = disp_ps1_rdy | bc(disp_ps1); e.r2 = disp_ps2_rdy | bc(disp_ps2);
               e.fu = disp_fu; e.rob = disp_rob;
               nq.push_back(e);
            end
         end
         q = nq;
      end
      @(posedge clk); #1;
      chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("err_fu", 64'(err_fu), 64'(e_err));
      for (int f = 0; f < NF; f++)
         chk($sformatf("payload%0d", f),
             64'({issue_op[f*OW +: OW], issue_pd[f*PW +: PW], issue_ps1[f*PW +: PW],
                  issue_ps2[f*PW +: PW], issue_rob[f*RW +: RW]}),
             64'({e_op[f], e_pd[f], e_ps1[f], e_ps2[f], e_rob[f]}));
   endtask

   initial begin
      for (int f = 0; f < NF; f++) begin
         e_op[f] = '0; e_pd[f] = '0; e_ps1[f] = '0; e_ps2[f] = '0; e_rob[f] = '0;
      end
      rst = 1'b1; fu_busy = '0;
      idle();
      disp(7'h33, 6'd40, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 4'd3);
      #12;
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("rst_disp_ready", 64'(disp_ready), 64'd1);
      chk("rst_err_fu", 64'(err_fu), 64'd0);
      chk("rst_issue_pd", 64'(issue_pd), 64'd0);
      rst = 1'b0;

      // single ready op, issues one edge after dispatch
      cycle();
      idle(); cycle();
      chk("first_issue_pd", 64'(issue_pd[PW-1:0]), 64'd40);
      idle(); cycle();

      // wakeup order: B woken first issues before A; then age order between C and D
      disp(7'h01, 6'd10, 6'd41, 1'b0, 6'd3, 1'b1, 2'd1, 4'd1); cycle();
      disp(7'h02, 6'd11, 6'd42, 1'b0, 6'd3, 1'b1, 2'd1, 4'd2); cycle();
      idle(); bcast(0, 6'd42); cycle();
      idle(); bcast(1, 6'd41); cycle();
      idle(); repeat (3) cycle();
      fu_busy = 3'b010;
      disp(7'h03, 6'd12, 6'd3, 1'b1, 6'd4, 1'b1, 2'd1, 4'd4); cycle();
      disp(7'h04, 6'd13, 6'd3, 1'b1, 6'd4, 1'b1, 2'd1, 4'd5); cycle();
      idle(); fu_busy = '0; repeat (3) cycle();

      // fill to capacity, refuse 17th, free one row by wakeup
      for (int i = 0; i < DEPTH; i++) begin
         disp(OW'(i), PW'(i), PW'(20 + i), 1'b0, 6'd5, 1'b1, 2'(i % NF), RW'(i));
         cycle();
      end
      disp(7'h55, 6'd55, 6'd60, 1'b0, 6'd61, 1'b0, 2'd0, 4'd9); cycle();
      bcast(2, 6'd24); cycle();
      wb_valid = '0; repeat (3) cycle();
      idle(); flush = 1'b1; cycle();
      idle(); cycle();

      // busy FU holds its ready op; two FUs issue together
      fu_busy = 3'b100;
      disp(7'h10, 6'd20, 6'd1, 1'b1, 6'd2, 1'b1, 2'd2, 4'd6); cycle();
      idle(); repeat (5) cycle();
      fu_busy = '0; cycle();
      disp(7'h11, 6'd21, 6'd60, 1'b0, 6'd2, 1'b1, 2'd0, 4'd7); cycle();
      disp(7'h12, 6'd22, 6'd60, 1'b0, 6'd2, 1'b1, 2'd1, 4'd8); cycle();
      idle(); bcast(0, 6'd60); cycle();
      idle(); repeat (2) cycle();

      // bad FU index sets sticky error; flush with concurrent dispatch
      disp(7'h13, 6'd23, 6'd1, 1'b1, 6'd2, 1'b1, 2'd3, 4'd9); cycle();
      idle(); cycle();
      for (int i = 0; i < 4; i++) begin
         disp(OW'(i + 32), PW'(i + 32), PW'(30 + i), 1'b0, 6'd2, 1'b1, 2'(i % NF), RW'(i));
         cycle();
      end
      disp(7'h14, 6'd24, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 4'd10); flush = 1'b1; cycle();
      idle(); cycle();

      // dispatch-time bypass, then resident wakeup latency
      disp(7'h15, 6'd25, 6'd45, 1'b0, 6'd2, 1'b1, 2'd0, 4'd11); bcast(1, 6'd45); cycle();
      idle(); repeat (2) cycle();
      disp(7'h16, 6'd26, 6'd46, 1'b0, 6'd2, 1'b1, 2'd0, 4'd12); cycle();
      idle(); cycle();
      bcast(0, 6'd46); cycle();
      idle(); repeat (2) cycle();

      // random traffic
      repeat (400) begin
         idle();
         flush = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1)
            disp(OW'($urandom), PW'($urandom), PW'($urandom_range(0, 15)), 1'($urandom),
                 PW'($urandom_range(0, 15)), 1'($urandom),
                 ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), RW'($urandom));
         for (int k = 0; k < NF; k++)
            if ($urandom_range(0, 1) == 1) bcast(k, PW'($urandom_range(0, 15)));
         for (int k = 0; k < NF; k++) fu_busy[k] = ($urandom_range(0, 3) == 0);
         cycle();
      end
      idle(); fu_busy = '0; repeat (4) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
